add3_accumulator: RTL



---
 rtl/add3_pkg.sv | 13 +
 rtl/add3_ripple.sv | 18 +
 rtl/add3_accumulator.sv | 91 +++++++++
 3 files changed

// File: rtl/add3_pkg.sv
// add3_pkg: shared widths, FSM states and counter helpers for the add3 accumulator.
package add3_pkg;
    localparam int DATA_W    = 3;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max(CNT_W_DEF);
endpackage

// File: rtl/add3_ripple.sv
// add3_ripple: combinational ripple-carry adder of two DATA_W-bit operands.
module add3_ripple
    import add3_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s,
    output logic              cout
);
    logic [DATA_W:0] c;

    assign c[0] = 1'b0;
    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[DATA_W];
endmodule

// File: rtl/add3_accumulator.sv
// add3_accumulator: folds NUM_OPS operands per frame through add3_ripple, counting carry-outs.
// Define ADD3_ACC_SAT_EN to force the running sum to 7 on any carry-out instead of wrapping.
module add3_accumulator
    import add3_pkg::*;
#(
    parameter int NUM_OPS = 4,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_carries,
    output logic              busy
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc, sum, acc_nxt;
    logic [CNT_W-1:0]  op_cnt, carry_cnt, carry_nxt;
    logic              ovf, cout, beat, last;

    add3_ripple u_add (.a(acc), .b(in_data), .s(sum), .cout(cout));

`ifdef ADD3_ACC_SAT_EN
    assign acc_nxt = cout ? '1 : sum;
`else
    assign acc_nxt = sum;
`endif
    assign carry_nxt = (cout && carry_cnt != CMAX) ? carry_cnt + CNT_W'(1) : carry_cnt;
    assign beat      = state == ACCUM && in_valid;
    assign last      = beat && op_cnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ACCUM : IDLE;
            ACCUM:   state_nxt = last ? DONE : ACCUM;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == ACCUM;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end

    // Result registers load only on the beat that enters DONE, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            op_cnt      <= '0;
            carry_cnt   <= '0;
            ovf         <= 1'b0;
            out_sum     <= '0;
            out_ovf     <= 1'b0;
            out_carries <= '0;
        end else begin
            if (state == IDLE && start) begin
                acc       <= '0;
                op_cnt    <= '0;
                carry_cnt <= '0;
                ovf       <= 1'b0;
            end else if (beat) begin
                acc       <= acc_nxt;
                op_cnt    <= op_cnt + CNT_W'(1);
                carry_cnt <= carry_nxt;
                ovf       <= ovf | cout;
            end
            if (last) begin
                out_sum     <= acc_nxt;
                out_ovf     <= ovf | cout;
                out_carries <= carry_nxt;
            end
        end
    end
endmodule
